// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory controller between an instruction-fetch
// read port (IF) and a data load/store port (D).
// A transaction runs IDLE -> BUSY -> DONE -> IDLE with a single owner chosen
// at grant. Reads stay in BUSY for READ_LATENCY cycles and writes for one.
// The owner's ack is pulsed in DONE.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, a tie is
// granted to whichever requester did not own the previous grant. When it is
// not defined, a tie is granted to the data port.
module mem_arbiter #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_address,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_op_length,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_input_data,
    output logic        mem_write,
    output logic [2:0]  mem_op_length,
    input  logic [31:0] mem_output_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter starts at zero on grant, so the last BUSY cycle of a read
    // is the one where the counter equals READ_LATENCY-1.
    localparam logic [3:0] LP_LAST_COUNT   = 4'(READ_LATENCY - 1);
    localparam logic [2:0] LP_IF_OP_LENGTH = 3'b010;

    state_t      r_state;
    logic        r_owner_d;        // 1: data port owns the transaction, 0: fetch port
    logic        r_is_write;
    logic [3:0]  r_count;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_input_data;
    logic        r_mem_write;
    logic [2:0]  r_mem_op_length;
    logic        r_if_ack;
    logic        r_d_ack;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    logic        r_last_owner_d;   // owner of the most recent grant
`endif

    logic        w_any_req;
    logic        w_grant_d;

    assign w_any_req = if_req | d_req;

    // Select the winner for a grant taken in IDLE.
    always_comb begin
        w_grant_d = 1'b0;
        if (d_req && !if_req) begin
            w_grant_d = 1'b1;
        end else if (d_req && if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_grant_d = ~r_last_owner_d;
`else
            w_grant_d = 1'b1;
`endif
        end else begin
            w_grant_d = 1'b0;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_owner_d        <= 1'b0;
            r_is_write       <= 1'b0;
            r_count          <= 4'd0;
            r_mem_address    <= 32'h0000_0000;
            r_mem_input_data <= 32'h0000_0000;
            r_mem_write      <= 1'b0;
            r_mem_op_length  <= 3'b000;
            r_if_ack         <= 1'b0;
            r_d_ack          <= 1'b0;
            r_if_rdata       <= 32'h0000_0000;
            r_d_rdata        <= 32'h0000_0000;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner_d   <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_if_ack    <= 1'b0;
                    r_d_ack     <= 1'b0;
                    r_mem_write <= 1'b0;
                    if (w_any_req) begin
                        r_state   <= ST_BUSY;
                        r_count   <= 4'd0;
                        r_owner_d <= w_grant_d;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_owner_d <= w_grant_d;
`endif
                        if (w_grant_d) begin
                            r_mem_address    <= d_address;
                            r_mem_input_data <= d_wdata;
                            r_mem_op_length  <= d_op_length;
                            r_is_write       <= d_write;
                            r_mem_write      <= d_write;
                        end else begin
                            // Fetches are always word reads; write data is
                            // left holding its previous value.
                            r_mem_address    <= if_address;
                            r_mem_op_length  <= LP_IF_OP_LENGTH;
                            r_is_write       <= 1'b0;
                            r_mem_write      <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_is_write || (r_count == LP_LAST_COUNT)) begin
                        r_state     <= ST_DONE;
                        r_mem_write <= 1'b0;
                        if (r_owner_d) begin
                            r_d_ack <= 1'b1;
                        end else begin
                            r_if_ack <= 1'b1;
                        end
                        if (!r_is_write) begin
                            if (r_owner_d) begin
                                r_d_rdata <= mem_output_data;
                            end else begin
                                r_if_rdata <= mem_output_data;
                            end
                        end
                    end else begin
                        r_count <= r_count + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_if_ack    <= 1'b0;
                    r_d_ack     <= 1'b0;
                    r_mem_write <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_if_ack    <= 1'b0;
                    r_d_ack     <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack         = r_if_ack;
    assign d_ack          = r_d_ack;
    assign if_rdata       = r_if_rdata;
    assign d_rdata        = r_d_rdata;
    assign mem_address    = r_mem_address;
    assign mem_input_data = r_mem_input_data;
    assign mem_write      = r_mem_write;
    assign mem_op_length  = r_mem_op_length;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. The driver issues requests and predicts
// each grant from the arbitration rules, then pushes the expected transaction.
// A negedge monitor compares DUT outputs against the front of that queue.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int RL   = 2;
    localparam int P_IF = 0;
    localparam int P_D  = 1;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req, d_req, d_write;
    logic [31:0] if_address, d_address, d_wdata, mem_output_data;
    logic [2:0]  d_op_length;
    logic        if_ack, d_ack, mem_write;
    logic [31:0] if_rdata, d_rdata, mem_address, mem_input_data;
    logic [2:0]  mem_op_length;

    mem_arbiter #(.READ_LATENCY(RL)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_address(if_address), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_op_length(d_op_length), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_input_data(mem_input_data), .mem_write(mem_write),
        .mem_op_length(mem_op_length), .mem_output_data(mem_output_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  oplen;
        logic [31:0] rdata;
        int          gap;
        int          drop;
    } txn_t;

    typedef struct {
        int          owner;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  oplen;
        logic [31:0] rdata;
        int          grant;
        int          ack_cycle;
    } exp_t;

    txn_t q_if[$];
    txn_t q_d[$];
    exp_t sb[$];
    int   ack_log[$];

    txn_t cur[2];
    bit   active[2];
    bit   granted[2];
    bit   line[2];
    int   grant_e[2];
    int   done_c[2];
    int   drop_c[2];
    int   gapcnt[2];

    int          free_edge = 0;
    int          last_owner = P_D;
    int          rd_edge = -1;
    logic [31:0] rd_val = 32'h0;
    logic [31:0] m_if_rdata = 32'h0;
    logic [31:0] m_d_rdata = 32'h0;
    exp_t        last_e;
    bit          mon_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp_v);
        end
    endtask

    function automatic txn_t mk_fix(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [2:0] ol, input logic [31:0] rd,
                                    input int gap, input int drop);
        txn_t t;
        t.write = wr; t.addr = a; t.wdata = wd; t.oplen = ol; t.rdata = rd;
        t.gap = gap; t.drop = drop;
        return t;
    endfunction

    function automatic txn_t mk_rand(input bit is_d);
        txn_t t;
        int   lat;
        t.write = is_d ? 1'($urandom_range(1, 0)) : 1'b0;
        t.addr  = $urandom();
        t.wdata = $urandom();
        t.oplen = is_d ? 3'($urandom_range(7, 0)) : 3'b010;
        t.rdata = $urandom();
        t.gap   = $urandom_range(3, 0);
        lat     = t.write ? 1 : RL;
        t.drop  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(lat, 1)) : -1;
        return t;
    endfunction

    function automatic void reset_model();
        for (int r = 0; r < 2; r++) begin
            active[r] = 1'b0; granted[r] = 1'b0; line[r] = 1'b0;
            grant_e[r] = -1; done_c[r] = -1; drop_c[r] = -1; gapcnt[r] = 0;
        end
        q_if.delete(); q_d.delete(); sb.delete();
        free_edge = 0; last_owner = P_D; rd_edge = -1;
        m_if_rdata = 32'h0; m_d_rdata = 32'h0;
        last_e.owner = P_D; last_e.write = 1'b0; last_e.addr = 32'h0; last_e.wdata = 32'h0;
        last_e.oplen = 3'b000; last_e.rdata = 32'h0; last_e.grant = -1; last_e.ack_cycle = -1;
    endfunction

    // Requester behaviour and arbitration prediction for the next edge.
    task automatic step();
        int   k = cyc;
        int   w;
        int   lat;
        txn_t nx;
        bit   has;
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            if (granted[r] && done_c[r] == k) begin
                active[r] = 1'b0; granted[r] = 1'b0; line[r] = 1'b0;
            end
            if (granted[r] && drop_c[r] == k) line[r] = 1'b0;
            if (!active[r]) begin
                has = 1'b0;
                if (r == P_IF && q_if.size() > 0) begin nx = q_if[0]; has = 1'b1; end
                if (r == P_D && q_d.size() > 0) begin nx = q_d[0]; has = 1'b1; end
                if (has) begin
                    if (gapcnt[r] >= nx.gap) begin
                        cur[r] = nx;
                        if (r == P_IF) void'(q_if.pop_front());
                        else void'(q_d.pop_front());
                        active[r] = 1'b1; line[r] = 1'b1; gapcnt[r] = 0;
                    end else begin
                        gapcnt[r]++;
                    end
                end
            end
        end
        if (k + 1 >= free_edge && (line[P_IF] || line[P_D])) begin
            if (line[P_IF] && line[P_D]) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = (last_owner == P_D) ? P_IF : P_D;
`else
                w = P_D;
`endif
            end else begin
                w = line[P_D] ? P_D : P_IF;
            end
            last_owner = w;
            lat = cur[w].write ? 1 : RL;
            e.owner = w; e.write = cur[w].write; e.addr = cur[w].addr; e.wdata = cur[w].wdata;
            e.oplen = (w == P_IF) ? 3'b010 : cur[w].oplen; e.rdata = cur[w].rdata;
            e.grant = k + 1; e.ack_cycle = k + 1 + lat;
            sb.push_back(e);
            granted[w] = 1'b1; grant_e[w] = k + 1;
            done_c[w] = k + 1 + lat + 1;
            drop_c[w] = (cur[w].drop >= 1) ? k + 1 + cur[w].drop : -1;
            free_edge = k + 1 + lat + 2;
            rd_edge = cur[w].write ? -1 : k + 1 + lat;
            rd_val = cur[w].rdata;
        end
        if_req = line[P_IF];
        d_req  = line[P_D];
        if (active[P_IF] && !(granted[P_IF] && grant_e[P_IF] <= k)) if_address = cur[P_IF].addr;
        else if_address = $urandom();
        if (active[P_D] && !(granted[P_D] && grant_e[P_D] <= k)) begin
            d_address = cur[P_D].addr; d_wdata = cur[P_D].wdata;
            d_write = cur[P_D].write; d_op_length = cur[P_D].oplen;
        end else begin
            d_address = $urandom(); d_wdata = $urandom();
            d_write = 1'($urandom_range(1, 0)); d_op_length = 3'($urandom_range(7, 0));
        end
        mem_output_data = (rd_edge == k + 1) ? rd_val : $urandom();
    endtask

    task automatic run_cycle();
        step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n = 0;
        while ((q_if.size() > 0 || q_d.size() > 0 || active[0] || active[1] || sb.size() > 0) && n < bound) begin
            run_cycle();
            n++;
        end
        chk(nm, 32'(sb.size() + q_if.size() + q_d.size()), 32'd0);
    endtask

    // Monitor: compare outputs against the expected transaction each cycle.
    task automatic mon_cycle();
        int   k = cyc;
        bit   e_mw = 1'b0, e_ia = 1'b0, e_da = 1'b0;
        exp_t f = last_e;
        if (sb.size() > 0 && k >= sb[0].grant) begin
            f = sb[0];
            if (k == f.grant) e_mw = f.write;
            if (k == f.ack_cycle) begin
                if (f.owner == P_IF) e_ia = 1'b1; else e_da = 1'b1;
                if (!f.write) begin
                    if (f.owner == P_IF) m_if_rdata = f.rdata; else m_d_rdata = f.rdata;
                end
            end
        end
        chk("if_ack", 32'(if_ack), 32'(e_ia));
        chk("d_ack", 32'(d_ack), 32'(e_da));
        chk("mem_write", 32'(mem_write), 32'(e_mw));
        chk("mem_address", mem_address, f.addr);
        chk("mem_op_length", 32'(mem_op_length), 32'(f.oplen));
        if (f.owner == P_D) chk("mem_input_data", mem_input_data, f.wdata);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        if (if_ack) ack_log.push_back(P_IF);
        if (d_ack) ack_log.push_back(P_D);
        if (sb.size() > 0 && k >= sb[0].ack_cycle) last_e = sb.pop_front();
    endtask

    always @(negedge clock) if (mon_en) mon_cycle();

    initial begin
        int n;
        int exp_ord[3];
        reset_n = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
        if_address = 32'h0; d_address = 32'h0; d_wdata = 32'h0; d_op_length = 3'b000;
        mem_output_data = 32'h0;
        reset_model();
        #1 reset_n = 1'b0;
        @(posedge clock);
        #2;
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_input_data", mem_input_data, 32'd0);
        chk("rst_mem_op_length", 32'(mem_op_length), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        mon_en = 1'b1;

        // Both requesters held together for three transactions.
        ack_log.delete();
        q_if.push_back(mk_fix(1'b0, 32'h100, 32'h0, 3'b010, 32'h1111_0001, 0, -1));
        q_if.push_back(mk_fix(1'b0, 32'h104, 32'h0, 3'b010, 32'h1111_0002, 0, -1));
        q_d.push_back(mk_fix(1'b0, 32'h200, 32'h0, 3'b011, 32'h2222_0001, 0, -1));
        wait_idle("tie_done", 100);
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord[0] = P_IF; exp_ord[1] = P_D; exp_ord[2] = P_IF;
`else
        exp_ord[0] = P_D; exp_ord[1] = P_IF; exp_ord[2] = P_IF;
`endif
        chk("tie_ack_count", 32'(ack_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < ack_log.size()) chk("tie_order", 32'(ack_log[i]), 32'(exp_ord[i]));
        end

        // Fetch read returning 0xDEADBEEF, then a data store.
        q_if.push_back(mk_fix(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 0, -1));
        wait_idle("if_read_done", 50);
        q_d.push_back(mk_fix(1'b1, 32'h20, 32'h55, 3'b010, 32'hBAD0_BAD0, 0, -1));
        wait_idle("d_write_done", 50);

        // Fetch drops req one cycle after grant; data req raised meanwhile.
        q_if.push_back(mk_fix(1'b0, 32'h40, 32'h0, 3'b010, 32'hCAFE_0040, 0, 1));
        run_cycle();
        q_d.push_back(mk_fix(1'b0, 32'h44, 32'h0, 3'b001, 32'hCAFE_0044, 0, -1));
        wait_idle("drop_done", 50);

        // Reset in the middle of a read.
        q_if.push_back(mk_fix(1'b0, 32'h80, 32'h0, 3'b010, 32'h8080_8080, 0, -1));
        n = 0;
        while (!(sb.size() > 0 && cyc == sb[0].grant + 1) && n < 20) begin
            run_cycle();
            n++;
        end
        chk("reach_busy", 32'(n < 20), 32'd1);
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_mem_write", 32'(mem_write), 32'd0);
        chk("midrst_if_ack", 32'(if_ack), 32'd0);
        chk("midrst_d_ack", 32'(d_ack), 32'd0);
        chk("midrst_mem_address", mem_address, 32'd0);
        chk("midrst_if_rdata", if_rdata, 32'd0);
        reset_model();
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) run_cycle();
        q_d.push_back(mk_fix(1'b0, 32'h90, 32'h0, 3'b010, 32'h9090_9090, 0, -1));
        wait_idle("post_reset_done", 50);

        // Randomised traffic from both ports.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(1, 0) == 0) q_if.push_back(mk_rand(1'b0));
            else q_d.push_back(mk_rand(1'b1));
        end
        wait_idle("random_done", 5000);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
